oled_init_seq: RTL and testbench

- Power-up/initialisation sequencer for the SSD1306-class OLED panel.
- Sits directly upstream of delay_gen: drives delay_ms/delay_en and consumes delay_fin.
- Also drives the panel power/reset pins and serialises SSD1306 command bytes over a write-only SPI link.
- Asserts done once the panel is on; display-content logic runs only after that.

---
 rtl/oled_init_seq_pkg.sv | 72 +++++++
 rtl/oled_init_seq_spi_byte_tx.sv | 116 +++++++++++
 rtl/oled_init_seq.sv | 171 +++++++++++++++++
 tb/tb_oled_init_seq.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/oled_init_seq_pkg.sv
// rtl/oled_init_seq_pkg.sv - shared types, opcodes and SSD1306 command bytes for the OLED init sequencer
package oled_init_seq_pkg;

    typedef enum logic [2:0] {
        INIT_IDLE       = 3'd0,
        INIT_STEP_FETCH = 3'd1,
        INIT_SPI_SEND   = 3'd2,
        INIT_SPI_WAIT   = 3'd3,
        INIT_DLY_REQ    = 3'd4,
        INIT_DLY_WAIT   = 3'd5,
        INIT_DLY_REL    = 3'd6,
        INIT_DONE       = 3'd7
    } init_state_e;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_SHIFT = 2'd1,
        TX_GAP   = 2'd2
    } tx_state_e;

    typedef enum logic [1:0] {
        OP_ACT  = 2'd0,
        OP_DLY  = 2'd1,
        OP_BYTE = 2'd2,
        OP_END  = 2'd3
    } step_op_e;

    typedef enum logic [1:0] {
        PIN_VDD  = 2'd0,
        PIN_RES  = 2'd1,
        PIN_VBAT = 2'd2,
        PIN_NONE = 2'd3
    } pin_sel_e;

    // arg holds the byte, the delay in ms, or {level, pin} for a pin action
    typedef struct packed {
        step_op_e    op;
        logic [11:0] arg;
    } step_t;

    localparam int STEP_W = 5;

    localparam logic [7:0] CMD_DISP_OFF    = 8'hAE;
    localparam logic [7:0] CMD_DISP_ON     = 8'hAF;
    localparam logic [7:0] CMD_CHARGE_PUMP = 8'h8D;
    localparam logic [7:0] CMD_CP_ENABLE   = 8'h14;
    localparam logic [7:0] CMD_PRECHARGE   = 8'hD9;
    localparam logic [7:0] CMD_PRECHG_VAL  = 8'hF1;
    localparam logic [7:0] CMD_CONTRAST    = 8'h81;
    localparam logic [7:0] CMD_CONTR_VAL   = 8'h0F;
    localparam logic [7:0] CMD_SEG_REMAP   = 8'hA1;
    localparam logic [7:0] CMD_COM_SCAN    = 8'hC8;
    localparam logic [7:0] CMD_COM_CFG     = 8'hDA;
    localparam logic [7:0] CMD_COM_CFG_VAL = 8'h20;

    function automatic step_t step_act(input pin_sel_e pin, input logic level);
        return '{op: OP_ACT, arg: {9'd0, level, pin}};
    endfunction

    function automatic step_t step_dly(input logic [11:0] ms);
        return '{op: OP_DLY, arg: ms};
    endfunction

    function automatic step_t step_byte(input logic [7:0] b);
        return '{op: OP_BYTE, arg: {4'd0, b}};
    endfunction

    function automatic step_t step_end();
        return '{op: OP_END, arg: 12'd0};
    endfunction

endpackage

// File: rtl/oled_init_seq_spi_byte_tx.sv
// rtl/oled_init_seq_spi_byte_tx.sv - write-only mode-3 SPI byte shifter, MSB first
module spi_byte_tx
    import oled_init_seq_pkg::*;
#(
    parameter int SPI_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       send,
    input  logic [7:0] data,
    output logic       busy,
    output logic       tx_done,
    output logic       cs_n,
    output logic       sclk,
    output logic       mosi
);

    localparam logic [7:0] DIV_M1 = 8'(SPI_DIV - 1);

    tx_state_e   state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shreg_q, shreg_d;
    logic        cs_n_q, cs_n_d;
    logic        sclk_q, sclk_d;
    logic        mosi_q, mosi_d;
    logic        tx_done_q, tx_done_d;
    logic        phase_end;

    assign phase_end = (cnt_q == DIV_M1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= TX_IDLE;
            cnt_q     <= 8'd0;
            bit_q     <= 3'd0;
            shreg_q   <= 8'd0;
            cs_n_q    <= 1'b1;
            sclk_q    <= 1'b1;
            mosi_q    <= 1'b0;
            tx_done_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shreg_q   <= shreg_d;
            cs_n_q    <= cs_n_d;
            sclk_q    <= sclk_d;
            mosi_q    <= mosi_d;
            tx_done_q <= tx_done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            TX_IDLE:  if (send) state_d = TX_SHIFT;
            TX_SHIFT: if (phase_end && sclk_q && bit_q == 3'd7) state_d = TX_GAP;
            TX_GAP:   if (phase_end) state_d = TX_IDLE;
            default:  state_d = TX_IDLE;
        endcase
    end

    // SCLK falls together with cs_n, so the last high phase doubles as the cs hold time
    always_comb begin
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        shreg_d   = shreg_q;
        cs_n_d    = cs_n_q;
        sclk_d    = sclk_q;
        mosi_d    = mosi_q;
        tx_done_d = 1'b0;
        case (state_q)
            TX_IDLE: begin
                if (send) begin
                    cnt_d   = 8'd0;
                    bit_d   = 3'd0;
                    shreg_d = {data[6:0], 1'b0};
                    mosi_d  = data[7];
                    cs_n_d  = 1'b0;
                    sclk_d  = 1'b0;
                end
            end
            TX_SHIFT: begin
                if (!phase_end) begin
                    cnt_d = cnt_q + 8'd1;
                end else begin
                    cnt_d = 8'd0;
                    if (!sclk_q) begin
                        sclk_d = 1'b1;
                    end else if (bit_q == 3'd7) begin
                        cs_n_d = 1'b1;
                        mosi_d = 1'b0;
                    end else begin
                        sclk_d  = 1'b0;
                        bit_d   = bit_q + 3'd1;
                        mosi_d  = shreg_q[7];
                        shreg_d = {shreg_q[6:0], 1'b0};
                    end
                end
            end
            TX_GAP: begin
                tx_done_d = (cnt_q == 8'd0);
                cnt_d     = phase_end ? 8'd0 : cnt_q + 8'd1;
            end
            default: ;
        endcase
    end

    assign busy    = (state_q != TX_IDLE);
    assign tx_done = tx_done_q;
    assign cs_n    = cs_n_q;
    assign sclk    = sclk_q;
    assign mosi    = mosi_q;

endmodule

// File: rtl/oled_init_seq.sv
// rtl/oled_init_seq.sv - SSD1306 power-up sequencer: supply/reset pins, delay requests and command bytes
module oled_init_seq
    import oled_init_seq_pkg::*;
#(
    parameter int          SPI_DIV   = 4,
    parameter logic [11:0] T_VDD_MS  = 12'd1,
    parameter logic [11:0] T_RES_MS  = 12'd1,
    parameter logic [11:0] T_VBAT_MS = 12'd100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [11:0] delay_ms,
    output logic        delay_en,
    input  logic        delay_fin,
    output logic        spi_cs_n,
    output logic        spi_sclk,
    output logic        spi_mosi,
    output logic        dc,
    output logic        res_n,
    output logic        vdd_n,
    output logic        vbat_n
);

    init_state_e        state_q, state_d;
    logic [STEP_W-1:0]  idx_q, idx_d;
    logic [11:0]        arg_q, arg_d;
    logic               rel_cnt_q, rel_cnt_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               delay_en_q, delay_en_d;
    logic [11:0]        delay_ms_q, delay_ms_d;
    logic               res_n_q, res_n_d;
    logic               vdd_n_q, vdd_n_d;
    logic               vbat_n_q, vbat_n_d;
    logic               spi_send;
    logic               spi_busy;
    logic               spi_tx_done;
    step_t              step;

    always_comb begin
        step = step_end();
        case (idx_q)
            5'd0:    step = step_act(PIN_VDD, 1'b0);
            5'd1:    step = step_dly(T_VDD_MS);
            5'd2:    step = step_byte(CMD_DISP_OFF);
            5'd3:    step = step_act(PIN_RES, 1'b0);
            5'd4:    step = step_dly(T_RES_MS);
            5'd5:    step = step_act(PIN_RES, 1'b1);
            5'd6:    step = step_dly(T_RES_MS);
            5'd7:    step = step_byte(CMD_CHARGE_PUMP);
            5'd8:    step = step_byte(CMD_CP_ENABLE);
            5'd9:    step = step_byte(CMD_PRECHARGE);
            5'd10:   step = step_byte(CMD_PRECHG_VAL);
            5'd11:   step = step_act(PIN_VBAT, 1'b0);
            5'd12:   step = step_dly(T_VBAT_MS);
            5'd13:   step = step_byte(CMD_CONTRAST);
            5'd14:   step = step_byte(CMD_CONTR_VAL);
            5'd15:   step = step_byte(CMD_SEG_REMAP);
            5'd16:   step = step_byte(CMD_COM_SCAN);
            5'd17:   step = step_byte(CMD_COM_CFG);
            5'd18:   step = step_byte(CMD_COM_CFG_VAL);
            5'd19:   step = step_byte(CMD_DISP_ON);
            default: step = step_end();
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= INIT_IDLE;
            idx_q      <= '0;
            arg_q      <= 12'd0;
            rel_cnt_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            delay_en_q <= 1'b0;
            delay_ms_q <= 12'd0;
            res_n_q    <= 1'b1;
            vdd_n_q    <= 1'b1;
            vbat_n_q   <= 1'b1;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            arg_q      <= arg_d;
            rel_cnt_q  <= rel_cnt_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            delay_en_q <= delay_en_d;
            delay_ms_q <= delay_ms_d;
            res_n_q    <= res_n_d;
            vdd_n_q    <= vdd_n_d;
            vbat_n_q   <= vbat_n_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            INIT_IDLE:       if (start) state_d = INIT_STEP_FETCH;
            INIT_STEP_FETCH: begin
                case (step.op)
                    OP_ACT:  state_d = INIT_STEP_FETCH;
                    OP_DLY:  state_d = INIT_DLY_REQ;
                    OP_BYTE: state_d = INIT_SPI_SEND;
                    default: state_d = INIT_DONE;
                endcase
            end
            INIT_SPI_SEND:   if (!spi_busy) state_d = INIT_SPI_WAIT;
            INIT_SPI_WAIT:   if (spi_tx_done) state_d = INIT_STEP_FETCH;
            INIT_DLY_REQ:    state_d = INIT_DLY_WAIT;
            INIT_DLY_WAIT:   if (delay_fin) state_d = INIT_DLY_REL;
            INIT_DLY_REL:    if (rel_cnt_q) state_d = INIT_STEP_FETCH;
            INIT_DONE:       state_d = INIT_DONE;
            default:         state_d = INIT_IDLE;
        endcase
    end

    // SPI_SEND waits for the shifter to finish its cs_n idle gap before issuing send
    always_comb begin
        idx_d      = idx_q;
        arg_d      = arg_q;
        delay_ms_d = delay_ms_q;
        res_n_d    = res_n_q;
        vdd_n_d    = vdd_n_q;
        vbat_n_d   = vbat_n_q;
        rel_cnt_d  = (state_q == INIT_DLY_REL) ? ~rel_cnt_q : 1'b0;
        spi_send   = (state_q == INIT_SPI_SEND) && !spi_busy;
        delay_en_d = (state_d == INIT_DLY_WAIT);
        done_d     = (state_d == INIT_DONE);
        busy_d     = (state_d != INIT_IDLE) && (state_d != INIT_DONE);
        if (state_q == INIT_STEP_FETCH && step.op != OP_END) begin
            idx_d = idx_q + 5'd1;
            arg_d = step.arg;
            if (step.op == OP_ACT) begin
                case (pin_sel_e'(step.arg[1:0]))
                    PIN_VDD:  vdd_n_d  = step.arg[2];
                    PIN_RES:  res_n_d  = step.arg[2];
                    PIN_VBAT: vbat_n_d = step.arg[2];
                    default:  ;
                endcase
            end
        end
        if (state_q == INIT_DLY_REQ) delay_ms_d = arg_q;
    end

    spi_byte_tx #(
        .SPI_DIV (SPI_DIV)
    ) u_spi_byte_tx (
        .clk     (clk),
        .rst     (rst),
        .send    (spi_send),
        .data    (arg_q[7:0]),
        .busy    (spi_busy),
        .tx_done (spi_tx_done),
        .cs_n    (spi_cs_n),
        .sclk    (spi_sclk),
        .mosi    (spi_mosi)
    );

    assign busy     = busy_q;
    assign done     = done_q;
    assign delay_en = delay_en_q;
    assign delay_ms = delay_ms_q;
    assign res_n    = res_n_q;
    assign vdd_n    = vdd_n_q;
    assign vbat_n   = vbat_n_q;
    assign dc       = 1'b0;

endmodule

// File: tb/tb_oled_init_seq.sv
// tb/tb_oled_init_seq.sv - randomized self-checking bench for oled_init_seq
module tb_oled_init_seq;

    localparam int DIV = 4;

    logic        clk = 1'b0;
    logic        rst, start, delay_fin;
    logic        busy, done, delay_en, spi_cs_n, spi_sclk, spi_mosi, dc, res_n, vdd_n, vbat_n;
    logic [11:0] delay_ms;

    always #5 clk = ~clk;

    oled_init_seq #(.SPI_DIV(DIV)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .delay_ms(delay_ms), .delay_en(delay_en), .delay_fin(delay_fin),
        .spi_cs_n(spi_cs_n), .spi_sclk(spi_sclk), .spi_mosi(spi_mosi), .dc(dc),
        .res_n(res_n), .vdd_n(vdd_n), .vbat_n(vbat_n)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d (0x%0h) exp=%0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // Reference: the command stream and delay list the panel must see
    logic [7:0] exp_bytes [12] = '{8'hAE, 8'h8D, 8'h14, 8'hD9, 8'hF1, 8'h81,
                                   8'h0F, 8'hA1, 8'hC8, 8'hDA, 8'h20, 8'hAF};
    int         exp_dly   [4]  = '{1, 1, 1, 100};

    // delay_gen stand-in: random latency, long hold on the VBAT delay, stray fin pulses when idle
    logic long_hold = 1'b0;
    initial begin
        int wait_n;
        logic pending;
        delay_fin = 1'b0;
        pending = 1'b0;
        wait_n = 0;
        forever begin
            @(posedge clk);
            #2;
            delay_fin = 1'b0;
            if (rst) pending = 1'b0;
            else if (delay_en && !pending) begin
                pending = 1'b1;
                wait_n = (long_hold && delay_ms == 12'd100) ? 1000 : int'($urandom_range(2, 8));
            end else if (pending) begin
                if (!delay_en) pending = 1'b0;
                else if (wait_n <= 1) begin delay_fin = 1'b1; pending = 1'b0; end
                else wait_n--;
            end else if ($urandom_range(0, 9) == 0) delay_fin = 1'b1;
        end
    end

    logic       mon_clr = 1'b1;
    int         cyc = 0;
    logic       p_cs = 1, p_sclk = 1, p_mosi = 0, p_en = 0, p_fin = 0, p_res = 1, p_vdd = 1, p_vbat = 1, p_rise = 0;
    logic [7:0] sh;
    int         bitc, run_len, phase_bad, mosi_bad, n_rises, cs_falls, last_cs_rise, min_gap;
    int         en_late, last_en_fall, min_en_low, hold_run, long_run, ms_unstable, dc_hi;
    int         vdd_fall, res_fall, res_rise, vbat_fall;
    logic [7:0] bytes_q[$];
    int         byte_start_q[$], byte_end_q[$], dly_ms_q[$], dly_cyc_q[$], send_cyc_q[$], txd_cyc_q[$];

    always @(negedge clk) begin
        cyc++;
        if (mon_clr) begin
            bitc = 0; run_len = 0; phase_bad = 0; mosi_bad = 0; n_rises = 0; cs_falls = 0;
            last_cs_rise = -1; min_gap = 1000000; en_late = 0; last_en_fall = -1; min_en_low = 1000000;
            hold_run = 0; long_run = 0; ms_unstable = 0; dc_hi = 0;
            vdd_fall = -1; res_fall = -1; res_rise = -1; vbat_fall = -1;
            bytes_q.delete(); byte_start_q.delete(); byte_end_q.delete();
            dly_ms_q.delete(); dly_cyc_q.delete(); send_cyc_q.delete(); txd_cyc_q.delete();
        end else begin
            if (!spi_cs_n && p_cs) begin
                cs_falls++;
                bitc = 0;
                byte_start_q.push_back(cyc);
                if (last_cs_rise >= 0 && cyc - last_cs_rise < min_gap) min_gap = cyc - last_cs_rise;
            end
            if (!spi_cs_n) begin
                if (p_cs) run_len = 1;
                else if (spi_sclk != p_sclk) begin
                    if (run_len != DIV) phase_bad++;
                    run_len = 1;
                end else run_len++;
            end else if (!p_cs) begin
                if (run_len != DIV) phase_bad++;
                last_cs_rise = cyc;
                if (bitc == 8) begin bytes_q.push_back(sh); byte_end_q.push_back(cyc); end
            end
            if (p_rise && spi_mosi !== p_mosi) mosi_bad++;
            p_rise = !spi_cs_n && !p_sclk && spi_sclk;
            if (p_rise) begin
                n_rises++;
                if (spi_mosi !== p_mosi) mosi_bad++;
                sh = {sh[6:0], spi_mosi};
                bitc++;
            end
            if (delay_en && !p_en) begin
                dly_ms_q.push_back(int'(delay_ms));
                dly_cyc_q.push_back(cyc);
                if (last_en_fall >= 0 && cyc - last_en_fall < min_en_low) min_en_low = cyc - last_en_fall;
                hold_run = 0;
            end
            if (delay_en) begin
                hold_run++;
                if (int'(delay_ms) != dly_ms_q[$]) ms_unstable++;
                if (delay_ms == 12'd100 && hold_run > long_run) long_run = hold_run;
            end
            if (!delay_en && p_en) last_en_fall = cyc;
            if (p_fin && p_en && delay_en) en_late++;
            if (!vdd_n && p_vdd && vdd_fall < 0) vdd_fall = cyc;
            if (!res_n && p_res && res_fall < 0) res_fall = cyc;
            if (res_n && !p_res && res_rise < 0) res_rise = cyc;
            if (!vbat_n && p_vbat && vbat_fall < 0) vbat_fall = cyc;
            if (dc !== 1'b0) dc_hi++;
            if (dut.spi_send) send_cyc_q.push_back(cyc);
            if (dut.spi_tx_done) txd_cyc_q.push_back(cyc);
        end
        p_cs = spi_cs_n; p_sclk = spi_sclk; p_mosi = spi_mosi; p_en = delay_en;
        p_fin = delay_fin; p_res = res_n; p_vdd = vdd_n; p_vbat = vbat_n;
    end

    task automatic clear_mon();
        mon_clr = 1'b1;
        repeat (2) @(negedge clk);
        mon_clr = 1'b0;
    endtask

    task automatic check_reset_vals(input string pfx);
        check({pfx, "_busy"}, busy, 0);
        check({pfx, "_done"}, done, 0);
        check({pfx, "_delay_en"}, delay_en, 0);
        check({pfx, "_delay_ms"}, delay_ms, 0);
        check({pfx, "_cs_n"}, spi_cs_n, 1);
        check({pfx, "_sclk"}, spi_sclk, 1);
        check({pfx, "_mosi"}, spi_mosi, 0);
        check({pfx, "_dc"}, dc, 0);
        check({pfx, "_res_n"}, res_n, 1);
        check({pfx, "_vdd_n"}, vdd_n, 1);
        check({pfx, "_vbat_n"}, vbat_n, 1);
    endtask

    task automatic run_seq(input logic with_hold);
        int t;
        int in_res;
        @(negedge clk);
        start = 1'b1;
        check("busy_before_start", busy, 0);
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", busy, 1);
        repeat ($urandom_range(50, 400)) @(negedge clk);
        check("busy_mid", busy, 1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        t = 0;
        while (!done && t < 20000) begin @(negedge clk); t++; end
        check("done_timeout", t < 20000, 1);
        check("done_end", done, 1);
        check("busy_end", busy, 0);
        check("n_bytes", bytes_q.size(), 12);
        for (int i = 0; i < 12; i++) check($sformatf("byte%0d", i), bytes_q[i], exp_bytes[i]);
        check("n_delays", dly_ms_q.size(), 4);
        for (int i = 0; i < 4; i++) check($sformatf("delay%0d", i), dly_ms_q[i], exp_dly[i]);
        check("n_rises", n_rises, 96);
        check("dc_high", dc_hi, 0);
        check("sclk_phase_len", phase_bad, 0);
        check("mosi_stable", mosi_bad, 0);
        check("cs_gap_min", min_gap >= DIV, 1);
        check("a1_send_to_done", txd_cyc_q[7] - send_cyc_q[7], 16 * DIV + 2);
        check("en_drop_after_fin", en_late, 0);
        check("en_low_between", min_en_low >= 2, 1);
        check("delay_ms_stable", ms_unstable, 0);
        check("vdd_before_byte", vdd_fall >= 0 && vdd_fall < byte_start_q[0], 1);
        check("ae_before_res", res_fall > byte_end_q[0], 1);
        in_res = 0;
        for (int i = 0; i < dly_cyc_q.size(); i++)
            if (dly_cyc_q[i] > res_fall && dly_cyc_q[i] < res_rise) begin
                in_res++;
                check("res_low_delay_ms", dly_ms_q[i], 1);
            end
        check("res_low_delays", in_res, 1);
        check("vbat_after_f1", vbat_fall > byte_end_q[4] && vbat_fall < byte_start_q[5], 1);
        check("pins_end", {vdd_n, res_n, vbat_n}, 3'b010);
        if (with_hold) check("long_hold_en", long_run >= 1000, 1);
    endtask

    initial begin
        int t, cs_snap, dly_snap, bad;
        rst = 1'b1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        rst = 1'b0;
        clear_mon();

        long_hold = 1'b1;
        run_seq(1'b1);

        // start held high through DONE must not restart anything
        cs_snap = cs_falls;
        dly_snap = dly_ms_q.size();
        bad = 0;
        start = 1'b1;
        repeat (300) begin
            @(negedge clk);
            if (!done || busy) bad++;
        end
        start = 1'b0;
        check("done_hold", bad, 0);
        check("done_no_bytes", cs_falls, cs_snap);
        check("done_no_delays", dly_ms_q.size(), dly_snap);

        // reset in the middle of the VBAT delay
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        clear_mon();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        t = 0;
        while (!(delay_en && delay_ms == 12'd100) && t < 20000) begin @(negedge clk); t++; end
        check("vbat_dly_timeout", t < 20000, 1);
        repeat ($urandom_range(1, 50)) @(negedge clk);
        rst = 1'b1;
        #1;
        check_reset_vals("midrst");
        @(negedge clk);
        rst = 1'b0;
        cs_snap = cs_falls;
        dly_snap = dly_ms_q.size();
        bad = 0;
        repeat (200) begin
            @(negedge clk);
            if (busy || delay_en || !spi_cs_n || !vdd_n) bad++;
        end
        check("post_rst_idle", bad, 0);
        check("post_rst_no_bytes", cs_falls, cs_snap);
        check("post_rst_no_delays", dly_ms_q.size(), dly_snap);

        long_hold = 1'b0;
        clear_mon();
        run_seq(1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
